// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_ADDRESS_WIDTH_D = 5;
    localparam int unsigned DATA_WIDTH_D       = 16;
    localparam int unsigned NUM_READ_D         = 2;

    typedef logic [RF_ADDRESS_WIDTH_D-1:0] rf_addr_t;
    typedef logic [DATA_WIDTH_D-1:0]       rf_data_t;

    localparam rf_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// A reservation beats a same-cycle write to the same register, and the
// zero register never becomes busy when it is hardwired.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned RF_ADDRESS_WIDTH = RF_ADDRESS_WIDTH_D,
    parameter int unsigned ZERO_REG         = 1
) (
    input  logic                                clk,
    input  logic                                asyn_n_rst,
    input  logic                                we,
    input  logic [RF_ADDRESS_WIDTH-1:0]         rd,
    input  logic                                res_en,
    input  logic [RF_ADDRESS_WIDTH-1:0]         res_addr,
    output logic [(2**RF_ADDRESS_WIDTH)-1:0]    busy_vec
);

    localparam int unsigned DEPTH = 2**RF_ADDRESS_WIDTH;

    // Set on reserve, else clear on write, else hold; bit 0 forced low for a hardwired zero register.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            busy_vec <= '0;
        end else begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                if (res_en && (res_addr == RF_ADDRESS_WIDTH'(a))) begin
                    busy_vec[a] <= 1'b1;
                end else if (we && (rd == RF_ADDRESS_WIDTH'(a))) begin
                    busy_vec[a] <= 1'b0;
                end
            end
            if (ZERO_REG != 0) begin
                busy_vec[ZERO_ADDR] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-read-port register file with write-first bypass, optional hardwired
// zero register and a per-register pending-write scoreboard.
module rf_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned RF_ADDRESS_WIDTH = RF_ADDRESS_WIDTH_D,
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_D,
    parameter int unsigned NUM_READ         = NUM_READ_D,
    parameter int unsigned ZERO_REG         = 1,
    parameter int unsigned BYPASS           = 1
) (
    input  logic                                    clk,
    input  logic                                    asyn_n_rst,
    input  logic                                    we,
    input  logic [RF_ADDRESS_WIDTH-1:0]             rd,
    input  logic [DATA_WIDTH-1:0]                   data_in,
    input  logic [NUM_READ-1:0]                     re,
    input  logic [NUM_READ*RF_ADDRESS_WIDTH-1:0]    rs,
    output logic [NUM_READ*DATA_WIDTH-1:0]          Q,
    output logic [NUM_READ-1:0]                     Q_busy,
    input  logic                                    res_en,
    input  logic [RF_ADDRESS_WIDTH-1:0]             res_addr,
    output logic [(2**RF_ADDRESS_WIDTH)-1:0]        busy_vec
);

    localparam int unsigned DEPTH = 2**RF_ADDRESS_WIDTH;
    localparam logic [RF_ADDRESS_WIDTH-1:0] ZA = RF_ADDRESS_WIDTH'(ZERO_ADDR);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_ok;

    assign wr_ok = we && !((ZERO_REG != 0) && (rd == ZA));

    rf_scoreboard #(
        .RF_ADDRESS_WIDTH (RF_ADDRESS_WIDTH),
        .ZERO_REG         (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .we         (we),
        .rd         (rd),
        .res_en     (res_en),
        .res_addr   (res_addr),
        .busy_vec   (busy_vec)
    );

    // Storage array: cleared on reset, written when the target is not the hardwired zero register.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
        end else if (wr_ok) begin
            regs[rd] <= data_in;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [RF_ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]       q_r;
        logic                        b_r;

        assign addr                        = rs[k*RF_ADDRESS_WIDTH +: RF_ADDRESS_WIDTH];
        assign Q[k*DATA_WIDTH +: DATA_WIDTH] = q_r;
        assign Q_busy[k]                   = b_r;

        // Registered read; zero register takes priority over the same-cycle write bypass.
        always_ff @(posedge clk or negedge asyn_n_rst) begin
            if (!asyn_n_rst) begin
                q_r <= '0;
                b_r <= 1'b0;
            end else if (re[k]) begin
                if ((ZERO_REG != 0) && (addr == ZA)) begin
                    q_r <= '0;
                    b_r <= 1'b0;
                end else if ((BYPASS != 0) && we && (rd == addr)) begin
                    q_r <= data_in;
                    b_r <= 1'b0;
                end else begin
                    q_r <= regs[addr];
                    b_r <= busy_vec[addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed testbench for rf_mp_sb: a BYPASS=1 instance and a BYPASS=0 instance share stimulus.
module tb_rf_mp_sb;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 2;

    logic            clk = 1'b0;
    logic            asyn_n_rst;
    logic            we;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   data_in;
    logic [NR-1:0]   re;
    logic [NR*AW-1:0] rs;
    logic            res_en;
    logic [AW-1:0]   res_addr;

    logic [NR*DW-1:0] q, q_nb;
    logic [NR-1:0]    qb, qb_nb;
    logic [31:0]      bv, bv_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_mp_sb #(
        .RF_ADDRESS_WIDTH (AW),
        .DATA_WIDTH       (DW),
        .NUM_READ         (NR),
        .ZERO_REG         (1),
        .BYPASS           (1)
    ) dut (
        .clk (clk), .asyn_n_rst (asyn_n_rst), .we (we), .rd (rd), .data_in (data_in),
        .re (re), .rs (rs), .Q (q), .Q_busy (qb),
        .res_en (res_en), .res_addr (res_addr), .busy_vec (bv)
    );

    rf_mp_sb #(
        .RF_ADDRESS_WIDTH (AW),
        .DATA_WIDTH       (DW),
        .NUM_READ         (NR),
        .ZERO_REG         (1),
        .BYPASS           (0)
    ) dut_nb (
        .clk (clk), .asyn_n_rst (asyn_n_rst), .we (we), .rd (rd), .data_in (data_in),
        .re (re), .rs (rs), .Q (q_nb), .Q_busy (qb_nb),
        .res_en (res_en), .res_addr (res_addr), .busy_vec (bv_nb)
    );

    task automatic idle();
        we = 1'b0; rd = '0; data_in = '0; re = '0; rs = '0; res_en = 1'b0; res_addr = '0;
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(); we = 1'b1; rd = a; data_in = d;
        tick();
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        idle(); re = 2'b01; rs = {5'd0, a};
        tick();
    endtask

    task automatic test_reset();
        asyn_n_rst = 1'b0;
        idle();
        tick();
        asyn_n_rst = 1'b1;
        tick();
        wr(5'd1, 16'h1111);
        wr(5'd2, 16'h2222);
        wr(5'd31, 16'hABCD);
        idle(); res_en = 1'b1; res_addr = 5'd2; tick();
        rd0(5'd1);
        checks++;
        if (q[15:0] !== 16'h1111) begin
            failures++; $display("FAIL preload_read got=%h exp=%h", q[15:0], 16'h1111);
        end
        idle();
        @(negedge clk);
        #2 asyn_n_rst = 1'b0;
        #1;
        checks++;
        if (q !== '0 || qb !== '0 || bv !== '0) begin
            failures++; $display("FAIL async_reset q=%h qb=%b bv=%h exp=0", q, qb, bv);
        end
        #1 asyn_n_rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd0(5'(i));
            checks++;
            if (q[15:0] !== 16'h0 || qb[0] !== 1'b0) begin
                failures++; $display("FAIL reset_clear a=%0d got=%h busy=%b exp=0", i, q[15:0], qb[0]);
            end
        end
        checks++;
        if (bv !== 32'h0) begin
            failures++; $display("FAIL reset_busy_vec got=%h exp=0", bv);
        end
    endtask

    task automatic test_write_read();
        wr(5'd5, 16'hBEEF);
        idle(); re = 2'b11; rs = {5'd5, 5'd5}; tick();
        checks++;
        if (q !== {16'hBEEF, 16'hBEEF} || qb !== 2'b00) begin
            failures++; $display("FAIL write_read q=%h qb=%b exp=beefbeef/00", q, qb);
        end
    endtask

    task automatic test_bypass();
        wr(5'd7, 16'h0042);
        idle(); we = 1'b1; rd = 5'd7; data_in = 16'h1234; re = 2'b01; rs = {5'd0, 5'd7};
        tick();
        checks++;
        if (q[15:0] !== 16'h1234) begin
            failures++; $display("FAIL bypass_on got=%h exp=1234", q[15:0]);
        end
        checks++;
        if (q_nb[15:0] !== 16'h0042) begin
            failures++; $display("FAIL bypass_off got=%h exp=0042", q_nb[15:0]);
        end
        rd0(5'd7);
        checks++;
        if (q_nb[15:0] !== 16'h1234) begin
            failures++; $display("FAIL bypass_off_after got=%h exp=1234", q_nb[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 16'hFFFF);
        rd0(5'd0);
        checks++;
        if (q[15:0] !== 16'h0) begin
            failures++; $display("FAIL zero_read got=%h exp=0", q[15:0]);
        end
        idle(); we = 1'b1; rd = 5'd0; data_in = 16'hFFFF; re = 2'b01; rs = '0; tick();
        checks++;
        if (q[15:0] !== 16'h0 || qb[0] !== 1'b0) begin
            failures++; $display("FAIL zero_bypass got=%h busy=%b exp=0", q[15:0], qb[0]);
        end
        idle(); res_en = 1'b1; res_addr = 5'd0; tick();
        checks++;
        if (bv[0] !== 1'b0) begin
            failures++; $display("FAIL zero_reserve busy=%b exp=0", bv[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle(); res_en = 1'b1; res_addr = 5'd3; tick();
        checks++;
        if (bv !== 32'h0000_0008) begin
            failures++; $display("FAIL reserve_set bv=%h exp=00000008", bv);
        end
        rd0(5'd3);
        checks++;
        if (qb[0] !== 1'b1) begin
            failures++; $display("FAIL reserve_read busy=%b exp=1", qb[0]);
        end
        wr(5'd3, 16'h5555);
        checks++;
        if (bv[3] !== 1'b0) begin
            failures++; $display("FAIL write_clear busy=%b exp=0", bv[3]);
        end
        idle(); re = 2'b11; rs = {5'd3, 5'd5}; tick();
        checks++;
        if (q !== {16'h5555, 16'hBEEF} || qb !== 2'b00) begin
            failures++; $display("FAIL two_port q=%h qb=%b exp=5555beef/00", q, qb);
        end
    endtask

    task automatic test_res_write_same();
        idle(); res_en = 1'b1; res_addr = 5'd9; we = 1'b1; rd = 5'd9; data_in = 16'h00AA;
        tick();
        checks++;
        if (bv[9] !== 1'b1) begin
            failures++; $display("FAIL res_wins busy=%b exp=1", bv[9]);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== {16'h5555, 16'hBEEF}) begin
                failures++; $display("FAIL hold cyc=%0d q=%h exp=5555beef", i, q);
            end
        end
        idle(); re = 2'b10; rs = {5'd9, 5'd0}; tick();
        checks++;
        if (q !== {16'h00AA, 16'hBEEF} || qb !== 2'b10) begin
            failures++; $display("FAIL res_write_data q=%h qb=%b exp=00aabeef/10", q, qb);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_res_write_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout exceeded 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-read-port register file with per-register pending-write scoreboard.
- Successor of the 2-read/1-write 16-bit file, with these additions:
  - full reset of every entry;
  - reads that are not blocked by writes;
  - write-first bypass;
  - optional hardwired zero register;
  - busy tracking for multi-cycle producers (loads, multiplier).
- Sits in the decode stage; the hazard unit consumes the busy flags.

Parameters:
- RF_ADDRESS_WIDTH, 5, register address width; depth DEPTH = 2**RF_ADDRESS_WIDTH.
- DATA_WIDTH, 16, register data width.
- NUM_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- asyn_n_rst  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- rd  in  RF_ADDRESS_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- re  in  NUM_READ  per-port read enable.
- rs  in  NUM_READ*RF_ADDRESS_WIDTH  read addresses; port k uses bits [k*AW +: AW].
- Q  out  NUM_READ*DATA_WIDTH  registered read data; port k uses bits [k*DW +: DW].
- Q_busy  out  NUM_READ  registered pending flag of the register read on port k.
- res_en  in  1  reserve request; marks res_addr pending.
- res_addr  in  RF_ADDRESS_WIDTH  register being reserved.
- busy_vec  out  DEPTH  live scoreboard bits, one per register.

Behaviour:
- Reset (asyn_n_rst=0):
  - effective immediately, independent of clk;
  - all DEPTH registers cleared to 0, scoreboard cleared to 0;
  - Q = 0, Q_busy = 0, busy_vec = 0.
  - Reset mid-operation discards pending writes and reservations.
  - First write after reset is possible on the first rising edge with asyn_n_rst=1.
- Write: on a clk edge with we=1, register[rd] <= data_in. Exception: ZERO_REG=1 and rd=0 -> no effect.
- Read latency is 1 cycle. On a clk edge with re[k]=1:
  - Q[k] <= register[rs[k]];
  - Q_busy[k] <= busy_vec[rs[k]].
- When re[k]=0, Q[k] and Q_busy[k] hold their values.
- Reads and writes proceed in the same cycle; a write never stalls a read.
- Read/write collision: re[k]=1, we=1, rs[k]=rd.
  - BYPASS=1: Q[k] <= data_in and Q_busy[k] <= 0.
  - BYPASS=0: Q[k] <= old register contents and Q_busy[k] <= old busy bit.
- Zero register with ZERO_REG=1: a read of address 0 always gives Q[k]=0 and Q_busy[k]=0, including under bypass.
- Scoreboard update, per clk edge, for each address a:
  - set if res_en=1 and res_addr=a;
  - else cleared if we=1 and rd=a;
  - else held.
- Simultaneous reserve and write to the same address: the reservation wins and the bit stays 1 (a new producer has been issued). The data write still happens.
- A reserve to address 0 is ignored when ZERO_REG=1.
- Re-reserving an already-busy register is legal; the bit stays 1. There is no counting, so only one outstanding producer per register.
- busy_vec is the registered scoreboard, with no combinational path from inputs.
- Multiple read ports may use the same address; each returns identical data.
- Addresses are always in range (full decode); no error condition exists.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_ADDRESS_WIDTH_D=5, DATA_WIDTH_D=16, NUM_READ_D=2;
  - a rf_addr_t typedef;
  - a rf_data_t typedef;
  - a ZERO_ADDR constant.
- Sub-module rf_scoreboard owns the DEPTH busy bits, the set/clear priority and the zero-register masking. It outputs busy_vec.
- The top level instantiates rf_scoreboard and holds the storage array and read-port generate loop.

Test Plan:
- Reset with all registers preloaded -> every address reads 0 and busy_vec=0; also assert reset asynchronously mid-cycle -> Q goes 0 before the next edge.
- Write 0xBEEF to r5, next cycle read r5 on port0 and port1 -> both Q=0xBEEF one cycle after re.
- Same cycle: we=1, rd=7, data_in=0x1234, re[0]=1, rs[0]=7, with r7 previously 0x0042 -> Q[0]=0x1234 (BYPASS=1); repeat with BYPASS=0 -> Q[0]=0x0042.
- Write 0xFFFF to r0 with ZERO_REG=1, then read r0 -> Q=0; res_en to r0 -> busy_vec[0] stays 0.
- res_en r3, then read r3 -> Q_busy=1, busy_vec[3]=1; later we to r3 -> busy_vec[3]=0 and a read returns the data with Q_busy=0.
- Same cycle: res_en r9 and we r9 with 0x00AA -> busy_vec[9]=1 and register 9 = 0x00AA; with re low, Q holds its prior value across 3 idle cycles.
